// File: rtl/led_frame.sv
// LED strip frame generator: four 0x00 start bytes, then brightness/blue/green/red per LED,
// then 0xFF end bytes, each byte handed to a downstream serialiser with a busy handshake.
module led_frame #(
  parameter int NUM_LEDS  = 60,
  parameter int END_BYTES = 4
) (
  input  logic        frame_clk,
  input  logic        frame_reset,
  input  logic        frame_start,
  input  logic [4:0]  brightness,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        pix_rd,
  output logic [7:0]  pix_addr,
  input  logic [23:0] pix_data,
  output logic        spi_start,
  output logic [7:0]  spi_data_out,
  input  logic        spi_busy
);

  localparam logic [10:0] COLOUR_END  = 11'(4 + 4 * NUM_LEDS);
  localparam logic [10:0] TOTAL_BYTES = 11'(4 + 4 * NUM_LEDS + END_BYTES);
  localparam logic [7:0]  LAST_LED    = 8'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FETCH        = 3'd1,
    FETCH_WAIT   = 3'd2,
    SEND         = 3'd3,
    WAIT_BUSY_HI = 3'd4,
    WAIT_BUSY_LO = 3'd5,
    DONE         = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  led_cnt_q, led_cnt_d;
  logic [4:0]  bright_q, bright_d;
  logic [23:0] hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pix_rd_q, pix_rd_d;
  logic [7:0]  pix_addr_q, pix_addr_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_data_q, spi_data_d;
  logic [10:0] byte_nxt;
  logic [7:0]  led_nxt;

  // Next-state logic; output registers are loaded from the state being entered
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    led_cnt_d  = led_cnt_q;
    bright_d   = bright_q;
    hold_d     = hold_q;
    pix_addr_d = pix_addr_q;
    spi_data_d = spi_data_q;
    byte_nxt   = byte_cnt_q + 11'd1;
    // LED index advances once its red byte completes, saturating at the last LED
    if ((byte_cnt_q >= 11'd4) && (byte_cnt_q < COLOUR_END) &&
        (byte_cnt_q[1:0] == 2'd3) && (led_cnt_q != LAST_LED)) begin
      led_nxt = led_cnt_q + 8'd1;
    end else begin
      led_nxt = led_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          bright_d   = brightness;
          byte_cnt_d = 11'd0;
          led_cnt_d  = 8'd0;
          spi_data_d = 8'h00;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        hold_d     = pix_data;
        spi_data_d = {3'b111, bright_q};
        state_d    = SEND;
      end
      SEND: state_d = WAIT_BUSY_HI;
      WAIT_BUSY_HI: begin
        if (spi_busy) begin
          state_d = WAIT_BUSY_LO;
        end else begin
          state_d = WAIT_BUSY_HI;
        end
      end
      WAIT_BUSY_LO: begin
        if (!spi_busy) begin
          byte_cnt_d = byte_nxt;
          led_cnt_d  = led_nxt;
          if (byte_nxt == TOTAL_BYTES) begin
            state_d = DONE;
          end else if (byte_nxt < 11'd4) begin
            spi_data_d = 8'h00;
            state_d    = SEND;
          end else if (byte_nxt < COLOUR_END) begin
            case (byte_nxt[1:0])
              2'd0: begin
                pix_addr_d = led_nxt;
                state_d    = FETCH;
              end
              2'd1: begin
                spi_data_d = hold_q[7:0];
                state_d    = SEND;
              end
              2'd2: begin
                spi_data_d = hold_q[15:8];
                state_d    = SEND;
              end
              default: begin
                spi_data_d = hold_q[23:16];
                state_d    = SEND;
              end
            endcase
          end else begin
            spi_data_d = 8'hFF;
            state_d    = SEND;
          end
        end else begin
          state_d = WAIT_BUSY_LO;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        byte_cnt_d = 11'd0;
        led_cnt_d  = 8'd0;
        pix_addr_d = 8'h00;
        spi_data_d = 8'h00;
      end
    endcase

    spi_start_d = (state_d == SEND);
    pix_rd_d    = (state_d == FETCH);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge frame_clk) begin
    if (frame_reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 11'd0;
      led_cnt_q   <= 8'd0;
      bright_q    <= 5'd0;
      hold_q      <= 24'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_rd_q    <= 1'b0;
      pix_addr_q  <= 8'h00;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      led_cnt_q   <= led_cnt_d;
      bright_q    <= bright_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_rd_q    <= pix_rd_d;
      pix_addr_q  <= pix_addr_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
    end
  end

  assign frame_busy   = busy_q;
  assign frame_done   = done_q;
  assign pix_rd       = pix_rd_q;
  assign pix_addr     = pix_addr_q;
  assign spi_start    = spi_start_q;
  assign spi_data_out = spi_data_q;

endmodule
